// File: rtl/shift_io_pkg.sv
// shift_io_pkg
//   Shared types and helpers for the latch/serial switch+LED link.
//   Used by the device-side responder (shift_io_responder, shift_io_sreg)
//   and by the link controller, which sizes its own bit counter with cnt_w().
//   Contents:
//     SHIFT_IO_WIDTH_DEF  default frame width (switch count = LED count)
//     state_t             responder FSM states
//     cnt_w(width)        bits needed to count 0..width inclusive

package shift_io_pkg;

    localparam int SHIFT_IO_WIDTH_DEF = 16;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // The counter must reach WIDTH itself (not WIDTH-1), hence width+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_io_sreg.sv
// shift_io_sreg
//   Generic WIDTH-bit shift register with parallel load, shifting towards the
//   MSB. Instantiated as the PISO (switch capture) and the SIPO (LED data
//   capture) of the responder. Load has priority over shift.
//   Ports:
//     clk    in   1      system clock, rising edge
//     rst_n  in   1      synchronous active-low reset, clears q
//     load   in   1      q <= pin
//     shift  in   1      q <= {q[WIDTH-2:0], sin}
//     pin    in   WIDTH  parallel load data
//     sin    in   1      serial input, enters at the LSB
//     q      out  WIDTH  register contents

module shift_io_sreg
    import shift_io_pkg::*;
#(
    parameter int WIDTH = SHIFT_IO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= pin;
        end else if (shift) begin
            r_q <= {r_q[WIDTH-2:0], sin};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/shift_io_responder.sv
// shift_io_responder
//   Device-side end of the latch/serial switch+LED link. Emulates the board's
//   PISO (switches) + SIPO (LEDs) chain: while latch is high the switches are
//   parallel-loaded; while latch is low one bit per clock leaves on dout and
//   one bit enters from din (both MSB first). A frame of exactly WIDTH bits is
//   committed to led when latch rises; any other length is reported as an
//   error and discarded.
//   Optional feature macro: SHIFT_IO_ERR_CNT_EN adds the err_count port, a
//   saturating count of bad frames. Without it the port and counter are absent
//   and everything else is unchanged.
//   Ports:
//     clk         in   1          system clock, rising edge
//     rst_n       in   1          synchronous active-low reset
//     latch       in   1          1 = load/commit, 0 = shift
//     din         in   1          serial LED data, MSB first
//     dout        out  1          serial switch data, MSB first (registered)
//     sw          in   WIDTH      parallel switch inputs
//     led         out  WIDTH      parallel LED outputs (registered)
//     frame_done  out  1          1-cycle pulse, good frame committed
//     frame_err   out  1          1-cycle pulse, frame length != WIDTH
//     err_count   out  ERR_CNT_W  saturating bad-frame count (macro only)
//
//   state    | meaning
//   ST_LOAD  | latch high: switches reloaded every clock, bit counter cleared
//   ST_SHIFT | latch low: bits moving; commit or error decided on latch rise

module shift_io_responder
    import shift_io_pkg::*;
#(
    parameter int WIDTH = SHIFT_IO_WIDTH_DEF
`ifdef SHIFT_IO_ERR_CNT_EN
   ,parameter int ERR_CNT_W = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 latch,
    input  logic                 din,
    output logic                 dout,
    input  logic [WIDTH-1:0]     sw,
    output logic [WIDTH-1:0]     led,
    output logic                 frame_done,
    output logic                 frame_err
`ifdef SHIFT_IO_ERR_CNT_EN
   ,output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_bitcnt;
    logic             r_ovf;
    logic [WIDTH-1:0] r_led;
    logic             r_frame_done;
    logic             r_frame_err;

    logic             w_shift;
    logic             w_frame_ok;
    logic [WIDTH-1:0] w_out_sr;
    logic [WIDTH-1:0] w_in_sr;

    // Both shift registers follow latch directly, so the first latch-low edge
    // is already shift #1 regardless of the FSM state.
    assign w_shift = ~latch;

    shift_io_sreg #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (latch),
        .shift (w_shift),
        .pin   (sw),
        .sin   (1'b0),
        .q     (w_out_sr)
    );

    // The SIPO never loads; it keeps its contents while latch is high.
    shift_io_sreg #(.WIDTH(WIDTH)) u_sipo (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b0),
        .shift (w_shift),
        .pin   ('0),
        .sin   (din),
        .q     (w_in_sr)
    );

    assign w_frame_ok = (r_bitcnt == CNT_FULL) && !r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD;
            r_bitcnt     <= '0;
            r_ovf        <= 1'b0;
            r_led        <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (!latch) begin
                        // bitcnt is always 0 in LOAD, so shift #1 sets it to 1.
                        r_state  <= ST_SHIFT;
                        r_bitcnt <= CNT_W'(1);
                    end else begin
                        r_bitcnt <= '0;
                        r_ovf    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (latch) begin
                        r_state  <= ST_LOAD;
                        r_bitcnt <= '0;
                        r_ovf    <= 1'b0;
                        if (w_frame_ok) begin
                            r_led        <= w_in_sr;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else if (r_bitcnt == CNT_FULL) begin
                        // Counter parks at WIDTH; the extra bit marks the frame bad.
                        r_ovf <= 1'b1;
                    end else begin
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign dout       = w_out_sr[WIDTH-1];
    assign led        = r_led;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

`ifdef SHIFT_IO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (r_frame_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
